// File: rtl/ram_pkg.sv
// Shared types and constant helpers for the banked RAM and its banks.
package ram_pkg;

    typedef enum logic [0:0] {
        RAM_CLEAR,
        RAM_READY
    } ram_state_t;

    // Number of bits needed to index n items (minimum 1).
    function automatic int unsigned ram_clog2(input int unsigned n);
        int unsigned bits;
        bits = 1;
        while ((32'd1 << bits) < n) begin
            bits++;
        end
        return bits;
    endfunction

    function automatic int unsigned ram_depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank with synchronous read. A write leaves dout untouched.
module ram_bank
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clock,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout
);

    localparam int unsigned WORDS = ram_depth(ADDR_BITS);

    logic [WIDTH-1:0] mem_q [WORDS];

    // dout only moves on a pure read, so the top can hold out across writes.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= din;
            end else begin
                dout <= mem_q[addr];
            end
        end
    end

endmodule

// File: rtl/ram_banked.sv
// Parametrised banked RAM: 1-cycle registered read with valid strobe, write-first
// read-during-write, and an optional zeroing sweep after reset.
module ram_banked
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned ADDR_BITS      = 9,
    parameter int unsigned BANK_BITS      = 3,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 load,
    input  logic                 read_en,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic                 ready
);

    localparam int unsigned NBANKS   = ram_depth(BANK_BITS);
    localparam int unsigned OFF_BITS = ADDR_BITS - BANK_BITS;
    localparam int unsigned SEL_BITS = (NBANKS > 1) ? ram_clog2(NBANKS) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_WORD = '1;

    ram_state_t           state_q;
    logic [ADDR_BITS-1:0] clr_cnt_q;
    logic                 ready_q;
    logic                 out_valid_q;
    logic                 rd_seen_q;
    logic [SEL_BITS-1:0]  bank_q;
    logic                 byp_q;
    logic [WIDTH-1:0]     byp_data_q;

    logic                 clearing;
    logic                 do_wr;
    logic                 do_rd;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [OFF_BITS-1:0]  mem_off;
    logic [SEL_BITS-1:0]  mem_sel;
    logic [WIDTH-1:0]     wr_data;
    logic [NBANKS-1:0]    bank_en;
    logic [WIDTH-1:0]     bank_dout [NBANKS];
    logic [WIDTH-1:0]     rd_mux;
    logic [WIDTH-1:0]     out_mux;

    assign clearing = (state_q == RAM_CLEAR);
    assign do_wr    = clearing | (ready_q & load);
    assign do_rd    = ready_q & read_en;
    assign mem_addr = clearing ? clr_cnt_q : address;
    assign wr_data  = clearing ? '0 : in;
    assign mem_off  = mem_addr[OFF_BITS-1:0];

    if (BANK_BITS > 0) begin : g_sel
        assign mem_sel = mem_addr[ADDR_BITS-1 -: SEL_BITS];
    end else begin : g_nosel
        assign mem_sel = '0;
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        assign bank_en[b] = (do_wr | do_rd) & (mem_sel == SEL_BITS'(b));

        ram_bank #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (OFF_BITS)
        ) u_bank (
            .clock (clock),
            .en    (bank_en[b]),
            .we    (do_wr),
            .addr  (mem_off),
            .din   (wr_data),
            .dout  (bank_dout[b])
        );
    end

    // Bank index and bypass flag are captured only on reads, so out holds between reads.
    always_comb begin
        rd_mux = '0;
        for (int unsigned b = 0; b < NBANKS; b++) begin
            if (bank_q == b[SEL_BITS-1:0]) begin
                rd_mux = bank_dout[b];
            end
        end
    end

    always_comb begin
        out_mux = '0;
        if (rd_seen_q) begin
            out_mux = byp_q ? byp_data_q : rd_mux;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) begin
                state_q <= RAM_CLEAR;
            end else begin
                state_q <= RAM_READY;
            end
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            rd_seen_q   <= 1'b0;
            bank_q      <= '0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            unique case (state_q)
                RAM_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_WORD) begin
                        state_q <= RAM_READY;
                        ready_q <= 1'b1;
                    end
                end
                RAM_READY: begin
                    ready_q <= 1'b1;
                end
            endcase

            out_valid_q <= do_rd;
            if (do_rd) begin
                rd_seen_q  <= 1'b1;
                bank_q     <= mem_sel;
                byp_q      <= do_wr;
                byp_data_q <= in;
            end
        end
    end

    assign out       = out_mux;
    assign out_valid = out_valid_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_ram_banked.sv
// Directed bench for ram_banked: default banked build plus a small unbanked no-clear build.
module tb_ram_banked;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, load, read_en, ready, out_valid;
    logic [15:0] din, dout;
    logic [8:0]  address;

    ram_banked dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (din),
        .address   (address),
        .load      (load),
        .read_en   (read_en),
        .out       (dout),
        .out_valid (out_valid),
        .ready     (ready)
    );

    logic       reset2_n, load2, read_en2, ready2, out_valid2;
    logic [7:0] din2, dout2;
    logic [3:0] address2;

    ram_banked #(
        .WIDTH          (8),
        .ADDR_BITS      (4),
        .BANK_BITS      (0),
        .CLEAR_ON_RESET (1'b0)
    ) dut2 (
        .clock     (clock),
        .reset_n   (reset2_n),
        .in        (din2),
        .address   (address2),
        .load      (load2),
        .read_en   (read_en2),
        .out       (dout2),
        .out_valid (out_valid2),
        .ready     (ready2)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        address = a;
        din     = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [8:0] a, input logic [15:0] exp);
        address = a;
        read_en = 1'b1;
        tick();
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq(tag, 32'(dout), 32'(exp));
        read_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int cycles;
        cycles = 0;
        while (!ready && cycles < 2000) begin
            tick();
            cycles++;
        end
        check_eq(tag, 32'(cycles), 32'd512);
    endtask

    initial begin
        int  cycles;
        bit  valid_seen;

        reset_n  = 1'b0;
        load     = 1'b0;
        read_en  = 1'b0;
        din      = '0;
        address  = '0;
        reset2_n = 1'b0;
        load2    = 1'b0;
        read_en2 = 1'b0;
        din2     = '0;
        address2 = '0;

        tick();
        tick();
        check_eq("rst_out", 32'(dout), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);

        // First sweep, with load/read_en poked during clear cycles 10-11.
        reset_n    = 1'b1;
        cycles     = 0;
        valid_seen = 1'b0;
        while (!ready && cycles < 2000) begin
            if (cycles == 9) begin
                address = 9'h000;
                din     = 16'hFFFF;
                load    = 1'b1;
                read_en = 1'b1;
            end
            if (cycles == 11) begin
                load    = 1'b0;
                read_en = 1'b0;
            end
            tick();
            cycles++;
            if (out_valid) valid_seen = 1'b1;
        end
        check_eq("clear_cycles", 32'(cycles), 32'd512);
        check_eq("valid_in_clear", 32'(valid_seen), 32'd0);

        rd("clr_rd_000", 9'h000, 16'h0000);
        tick();
        check_eq("valid_drop", 32'(out_valid), 32'd0);
        rd("clr_rd_0ff", 9'h0FF, 16'h0000);
        rd("clr_rd_1ff", 9'h1FF, 16'h0000);

        wr(9'h040, 16'hBEEF);
        wr(9'h1C0, 16'h1234);
        rd("rd_040", 9'h040, 16'hBEEF);
        rd("rd_1c0", 9'h1C0, 16'h1234);
        rd("rd_041", 9'h041, 16'h0000);

        // Back-to-back reads across banks.
        address = 9'h040;
        read_en = 1'b1;
        tick();
        check_eq("b2b_a", 32'(dout), 32'hBEEF);
        address = 9'h1C0;
        tick();
        check_eq("b2b_b_valid", 32'(out_valid), 32'd1);
        check_eq("b2b_b", 32'(dout), 32'h1234);
        read_en = 1'b0;

        // Output holds across idle cycles and writes to the same bank.
        wr(9'h1C1, 16'h7777);
        check_eq("hold_valid", 32'(out_valid), 32'd0);
        check_eq("hold_out", 32'(dout), 32'h1234);
        rd("rd_1c1", 9'h1C1, 16'h7777);

        // Read-during-write is write-first.
        rd("rdw_old", 9'h07F, 16'h0000);
        address = 9'h07F;
        din     = 16'hA5A5;
        load    = 1'b1;
        read_en = 1'b1;
        tick();
        load    = 1'b0;
        read_en = 1'b0;
        check_eq("rdw_valid", 32'(out_valid), 32'd1);
        check_eq("rdw_out", 32'(dout), 32'hA5A5);
        tick();
        rd("rdw_later", 9'h07F, 16'hA5A5);

        // Reset mid-operation, then again mid-sweep.
        wr(9'h100, 16'h5555);
        address = 9'h100;
        read_en = 1'b1;
        tick();
        check_eq("pre_rst_out", 32'(dout), 32'h5555);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_out", 32'(dout), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(ready), 32'd0);
        read_en = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        reset_n = 1'b0;
        #1;
        check_eq("sweep_rst_ready", 32'(ready), 32'd0);
        check_eq("sweep_rst_out", 32'(dout), 32'd0);
        tick();
        reset_n = 1'b1;
        wait_ready("resweep_cycles");
        rd("rd_100_cleared", 9'h100, 16'h0000);

        // Unbanked, no-clear variant.
        check_eq("v_rst_ready", 32'(ready2), 32'd0);
        reset2_n = 1'b1;
        check_eq("v_ready_pre", 32'(ready2), 32'd0);
        tick();
        check_eq("v_ready", 32'(ready2), 32'd1);
        for (int a = 0; a < 16; a++) begin
            address2 = 4'(a);
            din2     = 8'(a) ^ 8'h3C;
            load2    = 1'b1;
            tick();
        end
        load2    = 1'b0;
        read_en2 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            address2 = 4'(a);
            tick();
            check_eq($sformatf("v_rd_%0d_valid", a), 32'(out_valid2), 32'd1);
            check_eq($sformatf("v_rd_%0d", a), 32'(dout2), 32'(8'(a) ^ 8'h3C));
        end
        read_en2 = 1'b0;
        tick();
        check_eq("v_valid_drop", 32'(out_valid2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Parametrised successor to the fixed 512-word memory: width, depth and bank count set by parameters.
- Adds a registered (1-cycle) read with valid strobe, write-first read-during-write, and a hardware clear sweep after reset with a ready flag.
- Sits under the CPU/memory-map level as the generic data/instruction RAM; banks are gated so only the addressed bank is enabled per cycle.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 9, address width; DEPTH = 2**ADDR_BITS words.
- BANK_BITS, 3, number of bank-select MSBs; NBANKS = 2**BANK_BITS; legal range 0 <= BANK_BITS < ADDR_BITS.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the sweep, contents undefined.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- address  input  ADDR_BITS  word address; bank = address[ADDR_BITS-1 -: BANK_BITS], offset = remaining LSBs.
- load  input  1  write enable.
- read_en  input  1  read request.
- out  output  WIDTH  registered read data.
- out_valid  output  1  one-cycle strobe: out was updated by a read.
- ready  output  1  high when the block accepts load/read_en.

Behaviour:
- Reset (reset_n low, async):
  - out = 0, out_valid = 0, ready = 0, clear counter = 0.
  - state = CLEAR if CLEAR_ON_RESET, else READY.
  - ready goes high on the first clock edge after reset deasserts when CLEAR_ON_RESET = 0.
  - Memory array is not reset.
- State CLEAR:
  - Each cycle, write 0 to word at clear counter, then increment the counter.
  - After the write of word DEPTH-1, go to READY. ready = 1 from the next cycle, so exactly DEPTH clear cycles precede ready.
  - load and read_en are ignored; out_valid stays 0.
- State READY:
  - load = 1: in is written to address at the rising edge. Only the selected bank's enable is asserted.
  - read_en = 1: at the edge, out <= word at address and out_valid <= 1. Data is visible the cycle after the request (latency 1).
  - read_en = 0: out holds its last value; out_valid <= 0.
  - load and read_en on the same address in the same cycle: write-first, so out <= in.
  - Back-to-back reads every cycle: full throughput, out_valid stays high.
- Reset asserted mid-CLEAR or mid-operation: immediate return to reset values; the sweep restarts from word 0. Partially cleared contents carry no guarantee.
- Address wrap: none; every address value maps to exactly one word.
- State machine: CLEAR -> READY only; READY -> CLEAR only via reset.

Decomposition:
- Shared package ram_pkg:
  - typedef enum ram_state_t {RAM_CLEAR, RAM_READY}.
  - function clog2-style helpers and a DEPTH-derivation constant function.
- Sub-module ram_bank:
  - Parameters WIDTH and ADDR_BITS-BANK_BITS.
  - Ports clock, en, we, addr, din, dout; synchronous read.
  - Instantiated NBANKS times in a generate loop.
- Top level owns:
  - bank decode of load/en;
  - registered output mux, using the bank index delayed one cycle;
  - clear FSM and counter;
  - write-first bypass.

Test Plan:
- Clear sweep (defaults): release reset, count cycles -> ready rises after exactly 512 clock edges; reads of addresses 0, 255, 511 then return 0x0000 with out_valid pulsed one cycle after each request.
- Write/read across banks: write 0xBEEF @ 0x040 and 0x1234 @ 0x1C0, then read both -> out = 0xBEEF then 0x1234, each one cycle after read_en; the other bank's word is unaffected.
- Read-during-write: load = 1, read_en = 1, address 0x07F, in = 0xA5A5 (old value 0x0000) -> next cycle out = 0xA5A5; a later read of 0x07F returns 0xA5A5.
- Ignored during clear: assert load with in = 0xFFFF @ 0x000 and read_en at clear cycle 10 -> out_valid stays 0; after ready, a read of 0x000 returns 0x0000.
- Reset mid-operation: write 0x5555 @ 0x100, assert reset_n low at clear cycle 300 of a second sweep -> out = 0, ready = 0 immediately; the sweep restarts, ready rises 512 cycles after release, and 0x100 reads 0x0000.
- Parameter variant: WIDTH = 8, ADDR_BITS = 4, BANK_BITS = 0, CLEAR_ON_RESET = 0 -> ready = 1 one cycle after reset release; fill all 16 words with address^0x3C and read them back exactly.
